// File: rtl/muxn_stream_sel.sv
// muxn_stream_sel: NUM_IN-way, WIDTH-bit stream selector with one registered
// output stage. Channel choice is either an explicit index (mode=0) or a
// round-robin search over valid inputs (mode=1).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mode, sel           0 = explicit select by sel, 1 = round-robin
//   in_data/in_valid    flattened channel data (ch k at [k*WIDTH +: WIDTH]) and valids
//   in_ready            per-channel ready, one-hot or zero (combinational)
//   out_data/out_valid  registered selected data and valid
//   out_ready           consumer ready
//   out_src             registered index of the channel behind out_data
//   sel_err             registered out-of-range select flag, only when
//                       MUXN_SEL_ERR_EN is defined
//
// Optional feature macro: MUXN_SEL_ERR_EN
module muxn_stream_sel #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
`ifdef MUXN_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             sel_err_q, sel_err_d;

    logic             load_en_c;
    logic             grant_vld_c;
    logic [SEL_W-1:0] grant_idx_c;
    logic             fire_c;
    int unsigned      scan_idx_c;

    // Grant selection: explicit index or wrapping search from ptr+1.
    always_comb begin
        load_en_c   = !out_valid_q || out_ready;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        scan_idx_c  = 0;
        if (!mode) begin
            // Loop compare keeps out-of-range sel from indexing past in_valid.
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                if (sel == SEL_W'(k) && in_valid[k]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = SEL_W'(k);
                end
            end
        end else begin
            for (int unsigned i = 1; i <= NUM_IN; i++) begin
                scan_idx_c = 32'(ptr_q) + i;
                if (scan_idx_c >= NUM_IN) begin
                    scan_idx_c = scan_idx_c - NUM_IN;
                end
                if (!grant_vld_c && in_valid[scan_idx_c]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = SEL_W'(scan_idx_c);
                end
            end
        end
        fire_c = load_en_c && grant_vld_c;
    end

    // Ready goes only to the channel actually transferring this cycle.
    always_comb begin
        in_ready = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            in_ready[k] = fire_c && (grant_idx_c == SEL_W'(k));
        end
    end

    // Next-state for the output stage, round-robin pointer and error flag.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        sel_err_d   = 1'b0;
        if (load_en_c) begin
            out_valid_d = grant_vld_c;
            if (grant_vld_c) begin
                out_data_d = in_data[32'(grant_idx_c)*WIDTH +: WIDTH];
                out_src_d  = grant_idx_c;
            end
            sel_err_d = !mode && (32'(sel) >= NUM_IN);
        end
        // Explicit-mode grants leave the round-robin history untouched.
        if (fire_c && mode) begin
            ptr_d = grant_idx_c;
        end
    end

    // State registers; reset wins over any same-cycle transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= SEL_W'(NUM_IN - 1);
            sel_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

`ifdef MUXN_SEL_ERR_EN
    assign sel_err = sel_err_q;
`else
    // Flag logic has no consumer in this build and is trimmed.
    logic unused_sel_err;
    assign unused_sel_err = sel_err_q;
`endif

endmodule

// File: doc/muxn_stream_sel.md
Name: muxn_stream_sel

Overview:
- Parametrised successor to the 2-input datapath select.
- NUM_IN-way, WIDTH-bit selector with one registered output stage and valid/ready handshake on every input and on the output.
- Two select modes: explicit select index (CPU operand/forwarding paths) or round-robin arbitration among valid inputs (shared writeback / memory-request paths).
- Sits between producer stages and a single consumer in the LEGv8 pipeline.

Parameters:
- WIDTH, 64, data width per channel in bits (≥1).
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_IN) with minimum 1, select/source index width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  NUM_IN*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.
- out_src  output  SEL_W  index of the channel that produced out_data.
- sel_err  output  1  present only with MUXN_SEL_ERR_EN.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state changes occur on rising clk.
- Reset values: out_valid=0, out_data=0, out_src=0, sel_err=0. Round-robin last-grant pointer = NUM_IN-1, so the first search starts at channel 0.
- Reset has priority over any transfer in the same cycle. A transfer accepted in that cycle is discarded. in_ready may be high combinationally during reset, and producers must not treat it as a completed transfer.
- load_en = !out_valid || out_ready. This is a pipeline register with no bubble, giving full throughput of one transfer per cycle.
- Grant in mode=0:
  - Candidate = sel.
  - Grant if sel < NUM_IN and in_valid[sel] and load_en.
  - If sel ≥ NUM_IN, no grant is made.
- Grant in mode=1:
  - Scan channels starting at (ptr+1) mod NUM_IN, wrapping, and pick the first with in_valid set.
  - Grant it if load_en.
  - ptr updates to the granted index only on a grant. With no grant, ptr holds.
- in_ready[k] = load_en && (granted channel == k). At most one bit is set. This is a combinational path from out_ready, in_valid, sel and mode to in_ready, and it is permitted.
- On a grant of channel g at the clock edge: out_data <= in_data[g], out_src <= g, out_valid <= 1.
- If load_en and there is no grant: out_valid <= 0. out_data and out_src hold their old values (don't-care when invalid).
- If !load_en: all output registers hold. This is the stall case, where out_valid=1 and out_ready=0.
- Latency: input accepted in cycle N appears on out_* in cycle N+1.
- Out_data stability: while out_valid=1 and out_ready=0, out_data and out_src must not change.
- Mode and sel are sampled combinationally each cycle. A mode change takes effect for the same-cycle grant. ptr is preserved across a round-robin to explicit to round-robin mode switch.
- Simultaneous events: out_ready=1 with a new grant in the same cycle gives back-to-back transfers with no bubble. If all in_valid=0 in mode=1, no grant is made and ptr is unchanged.
- Wrap-around: with ptr=NUM_IN-1, the search starts at 0.

Optional Feature:
- Macro: MUXN_SEL_ERR_EN.
- With the macro defined:
  - sel_err is a registered output.
  - sel_err <= 1 for one cycle after any cycle where mode=0, sel ≥ NUM_IN, and load_en=1; otherwise sel_err <= 0.
  - Reset value is 0.
- Without the macro: the sel_err port and its logic are absent. Out-of-range sel silently produces no grant.

Test Plan:
- Reset and explicit select:
  - Setup: NUM_IN=4, WIDTH=8, reset held 2 cycles, then released; mode=0, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1.
  - Response: in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=8'hA5, out_src=2. During reset, out_valid=0 and out_data=0.
- Backpressure hold:
  - Stimulus: out_valid=1 with out_data=8'h11; out_ready=0 for 3 cycles while ch0 changes to 8'h22.
  - Response: in_ready=0, and out_data stays 8'h11 for all 3 cycles. Raising out_ready then gives 8'h22 on the next cycle with no bubble.
- Round-robin fairness and wrap:
  - Stimulus: mode=1, in_valid=4'b1111 constantly, out_ready=1.
  - Response: out_src sequence 0,1,2,3,0,1 on consecutive cycles.
  - Then set in_valid=4'b1001 after a grant of 3: the next grants are 0,3,0.
- Round-robin idle:
  - Stimulus: mode=1, in_valid=0 for 5 cycles, then in_valid=4'b0100.
  - Response: out_valid=0 throughout the idle period, then out_src=2 one cycle later. ptr is unchanged during the idle cycles.
- Out-of-range select:
  - Setup: NUM_IN=3, SEL_W=2, mode=0, sel=3, all in_valid=1.
  - Response: in_ready=0 and out_valid=0. With MUXN_SEL_ERR_EN, sel_err=1 one cycle later, then 0 after sel returns to 1.
- Reset mid-transfer:
  - Stimulus: assert reset in a cycle where a grant occurs and out_valid=1.
  - Response: next cycle out_valid=0, out_data=0, and ptr resets so that the first round-robin grant after reset is channel 0.
